// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Arbitrates two masters onto the single shared port of the 8-word, 16-bit data
// memory. It runs one transaction at a time, and each transaction takes three cycles:
//   IDLE   -> pick the owner round-robin and latch its we/addr/wdata.
//   ACCESS -> drive one memory strobe; capture the read data at the closing edge.
//   DONE   -> pulse ack to the owner for one cycle.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   req0/req1                 request, held high until ack
//   we0/we1                   1 = write, 0 = read
//   addr0/addr1               transaction address (passed through unchecked)
//   wdata0/wdata1             write data
//   ack0/ack1                 one-cycle completion pulse to the owner
//   rdata0/rdata1             last read data for each port (registered)
//   busy                      high while a transaction is in flight
//   gnt_id                    owner of the current/last transaction
//   mem_access_addr           memory address (holds the last latched value)
//   mem_write_data            memory write data (holds the last latched value)
//   mem_write_en, mem_read    memory strobes, high only in ACCESS
//   mem_read_data             combinational read data from memory

module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              gnt_id,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt_pick;
    logic              in_access;

    // Round-robin pick: on contention, the port that did not win last time wins.
    // Otherwise the single requester wins. When req0 alone is high, req1 = 0 selects port 0.
    assign gnt_pick = (req0 & req1) ? ~last_gnt_q : req1;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        ack0_d     = ack0_q;
        ack1_d     = ack1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    gnt_d      = gnt_pick;
                    last_gnt_d = gnt_pick;
                    we_d       = gnt_pick ? we1 : we0;
                    addr_d     = gnt_pick ? addr1 : addr0;
                    wdata_d    = gnt_pick ? wdata1 : wdata0;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                if (!we_q) begin
                    if (gnt_q) begin
                        rdata1_d = mem_read_data;
                    end else begin
                        rdata0_d = mem_read_data;
                    end
                end
                if (gnt_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
                state_d = StDone;
            end
            StDone: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // Strobes decode from the state register. Because of this, reset drops them
    // asynchronously.
    assign in_access       = (state_q == StAccess);
    assign mem_write_en    = in_access & we_q;
    assign mem_read        = in_access & ~we_q;
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;
    assign busy            = (state_q != StIdle);
    assign gnt_id          = gnt_q;
    assign ack0            = ack0_q;
    assign ack1            = ack1_q;
    assign rdata0          = rdata0_q;
    assign rdata1          = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: an 8-word memory model plus a transaction-level
// reference (per-port request queues, round-robin rule, 3-cycle transaction).
module tb_data_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam logic [15:0] INIT [0:7] = '{16'h0101, 16'h0202, 16'h0303, 16'hA5A5,
                                           16'h0505, 16'h0606, 16'h0707, 16'h0808};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, gnt_id, mem_write_en, mem_read;
    logic [DW-1:0] rdata0, rdata1, mem_write_data, mem_read_data;
    logic [AW-1:0] mem_access_addr;

    always #5 clk = ~clk;

    // Memory: synchronous write, combinational read gated by mem_read.
    logic [15:0] mem [0:7] = INIT;
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
    end
    assign mem_read_data = mem_read ? mem[mem_access_addr[2:0]] : '0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .gnt_id(gnt_id),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          gap;
    } txn_t;

    txn_t q0[$], q1[$];
    int   gap0 = 0, gap1 = 0;
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, t_ack0 = 0, t_ack1 = 0;
    int   ack_log[$];

    // Reference model state. m_cnt counts cycles since the grant (0 = none in flight).
    int          m_cnt;
    bit          m_owner, m_last, m_we;
    logic [15:0] m_addr, m_wdata, m_rd0, m_rd1;
    logic [15:0] ref_mem [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_owner = 0; m_last = 1; m_we = 0;
        m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_cnt == 0) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? !m_last : req1;
                m_last  = m_owner;
                m_we    = m_owner ? we1 : we0;
                m_addr  = m_owner ? addr1 : addr0;
                m_wdata = m_owner ? wdata1 : wdata0;
                m_cnt   = 1;
            end
        end else if (m_cnt == 1) begin
            if (m_we) ref_mem[m_addr[2:0]] = m_wdata;
            else if (m_owner) m_rd1 = ref_mem[m_addr[2:0]];
            else m_rd0 = ref_mem[m_addr[2:0]];
            m_cnt = 2;
        end else begin
            m_cnt = 0;
        end
    endtask

    task automatic check_cycle();
        check("busy", busy, m_cnt != 0);
        check("mem_read", mem_read, m_cnt == 1 && !m_we);
        check("mem_write_en", mem_write_en, m_cnt == 1 && m_we);
        check("strobe_overlap", mem_read & mem_write_en, 0);
        check("mem_access_addr", mem_access_addr, m_addr);
        check("mem_write_data", mem_write_data, m_wdata);
        check("ack0", ack0, m_cnt == 2 && !m_owner);
        check("ack1", ack1, m_cnt == 2 && m_owner);
        check("rdata0", rdata0, m_rd0);
        check("rdata1", rdata1, m_rd1);
        check("gnt_id", gnt_id, m_owner);
        if (ack0) begin ack_log.push_back(0); t_ack0 = cyc; end
        if (ack1) begin ack_log.push_back(1); t_ack1 = cyc; end
    endtask

    // A requester drops or replaces its request on the edge that closes its ack cycle.
    task automatic drive();
        if (m_cnt == 2 && !m_owner && q0.size() != 0) begin
            void'(q0.pop_front());
            gap0 = (q0.size() != 0) ? q0[0].gap : 0;
        end else if (gap0 > 0) gap0--;
        if (m_cnt == 2 && m_owner && q1.size() != 0) begin
            void'(q1.pop_front());
            gap1 = (q1.size() != 0) ? q1[0].gap : 0;
        end else if (gap1 > 0) gap1--;
        req0 = (q0.size() != 0) && (gap0 == 0);
        req1 = (q1.size() != 0) && (gap1 == 0);
        we0 = 0; addr0 = '0; wdata0 = '0;
        we1 = 0; addr1 = '0; wdata1 = '0;
        if (q0.size() != 0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        if (q1.size() != 0) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_cycle();
        drive();
    endtask

    task automatic run_drain(input int max_cyc);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_cnt != 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_within_budget", n < max_cyc, 1);
    endtask

    task automatic apply_reset();
        rst = 1;
        model_reset();
        q0.delete(); q1.delete(); gap0 = 0; gap1 = 0;
        drive();
        #1;
        check_cycle();
        step();
        step();
        rst = 0;
    endtask

    function automatic txn_t rnd_txn(input int max_gap);
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 16'($urandom);
        t.wdata = 16'($urandom);
        t.gap   = int'($urandom_range(0, max_gap));
        return t;
    endfunction

    initial begin
        logic [15:0] saved;
        int          n;
        ref_mem = INIT;
        model_reset();

        // Reset values.
        @(negedge clk);
        check_cycle();
        step();
        rst = 0;

        // Single read of mem[3] on port 0.
        q0.push_back('{we: 1'b0, addr: 16'd3, wdata: 16'h0, gap: 0});
        drive();
        run_drain(20);
        check("single_read_rdata0", rdata0, 16'hA5A5);
        check("single_read_rdata1", rdata1, 16'h0000);

        // Write then read back on port 1.
        q1.push_back('{we: 1'b1, addr: 16'd5, wdata: 16'h1234, gap: 0});
        q1.push_back('{we: 1'b0, addr: 16'd5, wdata: 16'h0, gap: 0});
        drive();
        run_drain(20);
        check("wr_rd_mem5", mem[5], 16'h1234);
        check("wr_rd_rdata1", rdata1, 16'h1234);

        // Simultaneous reads straight out of reset: port 0 first, port 1 three cycles later.
        apply_reset();
        ack_log.delete();
        q0.push_back('{we: 1'b0, addr: 16'd0, wdata: 16'h0, gap: 0});
        q1.push_back('{we: 1'b0, addr: 16'd1, wdata: 16'h0, gap: 0});
        drive();
        run_drain(20);
        check("simul_ack_spacing", t_ack1 - t_ack0, 3);
        check("simul_first_owner", (ack_log.size() != 0) ? ack_log[0] : -1, 0);

        // Sustained contention: 4 random transactions per port, requests back to back.
        apply_reset();
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rnd_txn(0));
            q1.push_back(rnd_txn(0));
        end
        drive();
        run_drain(100);
        check("contention_count", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size(); i++) check("contention_order", ack_log[i], i % 2);

        // Random traffic with idle gaps between a port's transactions.
        for (int i = 0; i < 12; i++) begin
            q0.push_back(rnd_txn(3));
            q1.push_back(rnd_txn(3));
        end
        gap0 = q0[0].gap;
        gap1 = q1[0].gap;
        drive();
        run_drain(600);

        // Reset in the middle of ACCESS of a port 0 write to addr 2.
        saved = ref_mem[2];
        q0.push_back('{we: 1'b1, addr: 16'd2, wdata: 16'hFFFF, gap: 0});
        drive();
        n = 0;
        while (m_cnt != 1 && n < 10) begin step(); n++; end
        check("reach_access", m_cnt, 1);
        rst = 1;
        #1;
        check("rst_mid_write_en", mem_write_en, 0);
        check("rst_mid_read", mem_read, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack0", ack0, 0);
        check("rst_mid_addr", mem_access_addr, 0);
        check("rst_mid_wdata", mem_write_data, 0);
        check("rst_mid_gnt", gnt_id, 0);
        check("rst_mid_rdata0", rdata0, 0);
        check("rst_mid_rdata1", rdata1, 0);
        model_reset();
        q0.delete(); q1.delete(); gap0 = 0; gap1 = 0;
        drive();
        step();
        step();
        rst = 0;
        step();
        check("rst_mid_mem2", mem[2], saved);

        // Write to addr 7, then stay idle for 10 cycles.
        q0.push_back('{we: 1'b1, addr: 16'd7, wdata: 16'($urandom), gap: 0});
        drive();
        run_drain(20);
        for (int i = 0; i < 10; i++) step();
        check("idle_addr_hold", mem_access_addr, 16'd7);
        check("idle_busy", busy, 0);
        check("idle_mem7", mem[7], ref_mem[7]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the single-port 16-bit data memory (8 words, synchronous write, read gated by `mem_read`). It sits between two masters (port 0: CPU load/store path; port 1: debug/DMA loader) and the memory's shared address/data port. It grants one transaction at a time in round-robin order, drives the memory strobes for exactly one cycle, captures read data, and returns a one-cycle acknowledge to the owner.

## Interface
Parameters:
- `ADDR_W`, 16, address width passed through to the memory (memory decodes `[2:0]`)
- `DATA_W`, 16, data width

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0` / `req1`  in  1  request, held high until ack
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while req high
- `addr0` / `addr1`  in  ADDR_W  transaction address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  last read data for that port (registered)
- `busy`  out  1  high whenever state ≠ IDLE
- `gnt_id`  out  1  owner of current/last transaction
- `mem_access_addr`  out  ADDR_W  to memory
- `mem_write_data`  out  DATA_W  to memory
- `mem_write_en`  out  1  to memory
- `mem_read`  out  1  to memory
- `mem_read_data`  in  DATA_W  from memory (combinational read)

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if `req0|req1` at the rising edge, pick the owner, latch its `we`, `addr`, `wdata` into internal registers, and set `gnt_id`. Next state is ACCESS. With no request, remain in IDLE.
- Arbitration: round-robin on `last_gnt` (reset 1, so port 0 wins first). When both requests are high, grant `~last_gnt`. When only one is high, grant it. `last_gnt` updates on every grant.
- ACCESS, one cycle: `mem_access_addr`/`mem_write_data` come from the latched registers. `mem_write_en` = latched `we`; `mem_read` = ~latched `we`. At the closing edge:
  - A read stores `mem_read_data` into the owner's `rdata`.
  - The owner's `ack` is set.
  - Next state is DONE.
- DONE, one cycle: owner's `ack` high, strobes low. Next state is IDLE, with `ack` cleared.
- Strobes (`mem_write_en`, `mem_read`) are high only in ACCESS. In IDLE and DONE, `mem_access_addr`/`mem_write_data` hold their last latched values.
- Writes never modify `rdata*`. The non-owner's `rdata` and `ack` are untouched.
- Requester rule: deassert `req` (or present a new transaction) on the edge at which `ack` is seen high. A `req` still high in the IDLE cycle after DONE is a new transaction.
- The full ADDR_W address is passed through; no range check.

## Timing
- Reset values:
  - state IDLE; `ack0`, `ack1`, `busy`, `mem_write_en`, `mem_read` = 0.
  - `rdata0`, `rdata1`, `mem_access_addr`, `mem_write_data` = 0; `gnt_id` = 0; `last_gnt` = 1.
- Latency: `req` sampled at edge E0 → ACCESS in cycle E0..E1 → `ack` high in cycle E1..E2, with `rdata` valid from E1.
- Throughput: one transaction per 3 cycles. Continuous requests from both ports alternate 0,1,0,1.
- A request arriving while `busy` waits; no loss, no reorder within a port.
- Reset asserted mid-transaction: immediate return to IDLE, strobes drop asynchronously, no `ack`, transaction discarded. A write whose ACCESS closing edge coincides with reset assertion is undefined; the bench must avoid it.
- Reset deasserted: the first grant is possible at the first rising edge with a request present.

## Test plan
- Single read: mem[3]=16'hA5A5; `req0`=1, `we0`=0, `addr0`=3 → `mem_read`=1 for exactly one cycle with addr 3; `ack0` pulses 2 cycles after the sample edge; `rdata0`=16'hA5A5; `rdata1` stays 0.
- Write then read-back on port 1: write 16'h1234 to addr 5, then read addr 5 → one-cycle `mem_write_en`; mem[5]=16'h1234; `rdata1`=16'h1234; `ack1` pulses twice, 3+ cycles apart.
- Simultaneous requests from reset: both ports read (addr 0 and 1) → port 0 granted first, port 1 next; `ack0` precedes `ack1` by exactly 3 cycles.
- Sustained contention: both `req` held with new transactions after each ack for 8 transactions → grants alternate 0,1,0,1…; each port completes 4; `mem_read` and `mem_write_en` are never both high.
- Reset mid-ACCESS (port 0 write 16'hFFFF to addr 2): assert `rst` during ACCESS away from the edge → strobes drop at once; no `ack0`; mem[2] unchanged; all outputs return to reset values.
- Idle hold: no requests for 10 cycles after a write to addr 7 → `busy`=0, strobes 0, `mem_access_addr` stays 7.
